// File: rtl/mux2_arb_pkg.sv
// mux2_arb_pkg
// Shared encodings for the round-robin 2:1 select arbiter.
//   slot_e  : output register occupancy (SLOT_EMPTY / SLOT_FULL)
//   lock_e  : burst lock owner (LOCK_NONE / LOCK_REQ0 / LOCK_REQ1)
//   REQ0/1  : requester index constants, also the mux select values
//   lock_for: maps a requester index to the lock state that holds it
package mux2_arb_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_REQ0 = 2'd1,
    LOCK_REQ1 = 2'd2
  } lock_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic lock_e lock_for(input logic idx);
    return (idx == REQ1) ? LOCK_REQ1 : LOCK_REQ0;
  endfunction

endpackage

// File: rtl/mux2_rr_pick.sv
// mux2_rr_pick
// Purely combinational grant decision for the two-requester arbiter.
// Ports:
//   req0_valid, req1_valid : in  requester valids
//   prio                   : in  requester favoured on a tie
//   lock                   : in  burst lock owner (LOCK_NONE when unlocked)
//   grant                  : out winning requester index
//   grant_valid            : out grant refers to a requester that is valid
module mux2_rr_pick
  import mux2_arb_pkg::*;
(
  input  logic  req0_valid,
  input  logic  req1_valid,
  input  logic  prio,
  input  lock_e lock,
  output logic  grant,
  output logic  grant_valid
);

  // A lock pins the grant to its owner even while the owner is idle, so the
  // other requester cannot slip a beat into the middle of a burst.
  always_comb begin
    grant       = prio;
    grant_valid = 1'b0;
    case (lock)
      LOCK_REQ0: begin
        grant       = REQ0;
        grant_valid = req0_valid;
      end
      LOCK_REQ1: begin
        grant       = REQ1;
        grant_valid = req1_valid;
      end
      default: begin
        if (req0_valid && req1_valid) begin
          grant       = prio;
          grant_valid = 1'b1;
        end else if (req0_valid) begin
          grant       = REQ0;
          grant_valid = 1'b1;
        end else if (req1_valid) begin
          grant       = REQ1;
          grant_valid = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter
// Round-robin arbiter and sequencer for a time-shared SIZE-wide 2:1 select
// datapath. Two valid/ready requesters compete for one registered output
// slot, which is presented downstream with its own valid/ready handshake.
// Ports:
//   clk, rst_n                          : clock, async active-low reset
//   req0_valid/data/last, req0_ready    : requester 0 handshake
//   req1_valid/data/last, req1_ready    : requester 1 handshake
//   out_valid, out_data, out_src        : registered beat and its source
//   out_ready                           : downstream accepts the beat
//   select                              : mux select, 1 = requester 1
// Optional feature: define VL_MUX2_ARB_LOCK_EN to enable burst lock, where a
// requester keeps the grant until it delivers a beat with last=1. Without the
// macro req*_last are ignored and no lock state exists.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int SIZE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [SIZE-1:0] req0_data,
  input  logic            req0_last,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [SIZE-1:0] req1_data,
  input  logic            req1_last,
  output logic            req1_ready,
  output logic            out_valid,
  output logic [SIZE-1:0] out_data,
  output logic            out_src,
  input  logic            out_ready,
  output logic            select
);

  slot_e           slot_q;
  slot_e           slot_d;
  lock_e           lock_q;
  logic            prio_q;
  logic            prio_d;
  logic            sel_q;
  logic            grant;
  logic            grant_valid;
  logic            can_accept;
  logic            take;
  logic            prio_update;
  logic [SIZE-1:0] mux_data;

  mux2_rr_pick u_pick (
    .req0_valid  (req0_valid),
    .req1_valid  (req1_valid),
    .prio        (prio_q),
    .lock        (lock_q),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Readys and select are gated by rst_n so nothing looks accepted while the
  // block is held in reset. With no valid requester select keeps its last
  // value instead of following prio, so the datapath does not toggle idly.
  always_comb begin
    can_accept = (slot_q == SLOT_EMPTY) || out_ready;
    take       = rst_n && can_accept && grant_valid;
    req0_ready = take && (grant == REQ0);
    req1_ready = take && (grant == REQ1);
    select     = !rst_n ? REQ0 : (grant_valid ? grant : sel_q);
    mux_data   = (grant == REQ1) ? req1_data : req0_data;
  end

`ifdef VL_MUX2_ARB_LOCK_EN
  logic  accept_last;
  lock_e lock_d;

  // A beat with last=0 hands the grant to its sender until a last=1 beat
  // closes the burst; the tie-break pointer only moves when a burst ends.
  always_comb begin
    accept_last = (grant == REQ1) ? req1_last : req0_last;
    prio_update = take && accept_last;
    lock_d      = lock_q;
    if (take) begin
      lock_d = accept_last ? LOCK_NONE : lock_for(grant);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= LOCK_NONE;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  logic unused_last;

  // Every beat is arbitrated on its own, so the pointer moves on each accept.
  assign unused_last = req0_last ^ req1_last;
  assign lock_q      = LOCK_NONE;
  assign prio_update = take;
`endif

  // The requester just served loses the next tie.
  always_comb begin
    prio_d = prio_q;
    if (prio_update) begin
      prio_d = !grant;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= SLOT_EMPTY;
    end else begin
      slot_q <= slot_d;
    end
  end

  // Slot next state: an accept always leaves the slot full (covers the
  // back-to-back drain+accept case); a drain alone empties it.
  always_comb begin
    slot_d = slot_q;
    case (slot_q)
      SLOT_EMPTY: if (take) slot_d = SLOT_FULL;
      SLOT_FULL: begin
        if (take) begin
          slot_d = SLOT_FULL;
        end else if (out_ready) begin
          slot_d = SLOT_EMPTY;
        end
      end
      default: slot_d = SLOT_EMPTY;
    endcase
  end

  // Slot outputs.
  always_comb begin
    out_valid = (slot_q == SLOT_FULL);
  end

  // Output beat, pointer and select history. Data and source only change on
  // an accept, so they stay stable through any downstream stall or drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_src  <= REQ0;
      prio_q   <= REQ0;
      sel_q    <= REQ0;
    end else begin
      if (take) begin
        out_data <= mux_data;
        out_src  <= grant;
      end
      prio_q <= prio_d;
      sel_q  <= select;
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter
// Directed, table-driven bench for mux2_rr_arbiter with SIZE=4. Each vector
// is one clock cycle: inputs, the expected combinational readys/select in
// that cycle, and the expected registered outputs after the clock edge.
// Burst-lock sequences are included when VL_MUX2_ARB_LOCK_EN is defined.
module tb_mux2_rr_arbiter;

  localparam int SIZE = 4;

  typedef struct {
    logic            r0v;
    logic [SIZE-1:0] r0d;
    logic            r0l;
    logic            r1v;
    logic [SIZE-1:0] r1d;
    logic            r1l;
    logic            ordy;
    logic            e_r0rdy;
    logic            e_r1rdy;
    logic            e_sel;
    logic            e_ov;
    logic [SIZE-1:0] e_od;
    logic            e_os;
  } vec_t;

  logic            clk;
  logic            rst_n;
  logic            req0_valid;
  logic [SIZE-1:0] req0_data;
  logic            req0_last;
  logic            req0_ready;
  logic            req1_valid;
  logic [SIZE-1:0] req1_data;
  logic            req1_last;
  logic            req1_ready;
  logic            out_valid;
  logic [SIZE-1:0] out_data;
  logic            out_src;
  logic            out_ready;
  logic            select;

  int assertCount = 0;
  int failCount   = 0;

  vec_t mainVecs[$];
  vec_t lockVecs[$];

  mux2_rr_arbiter #(.SIZE(SIZE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .select     (select)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r0v, input logic [SIZE-1:0] r0d,
                              input logic r0l, input logic r1v,
                              input logic [SIZE-1:0] r1d, input logic r1l,
                              input logic ordy, input logic e_r0rdy,
                              input logic e_r1rdy, input logic e_sel,
                              input logic e_ov, input logic [SIZE-1:0] e_od,
                              input logic e_os);
    vec_t v;
    v.r0v = r0v; v.r0d = r0d; v.r0l = r0l;
    v.r1v = r1v; v.r1d = r1d; v.r1l = r1l;
    v.ordy = ordy;
    v.e_r0rdy = e_r0rdy; v.e_r1rdy = e_r1rdy; v.e_sel = e_sel;
    v.e_ov = e_ov; v.e_od = e_od; v.e_os = e_os;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req0_valid = v.r0v;
    req0_data  = v.r0d;
    req0_last  = v.r0l;
    req1_valid = v.r1v;
    req1_data  = v.r1d;
    req1_last  = v.r1l;
    out_ready  = v.ordy;
  endtask

  // Called right after inputs change at a falling edge: checks this cycle's
  // combinational outputs, then the registers after the rising edge.
  task automatic checkOutput(input vec_t v, input string tag);
    #1;
    check({tag, ".req0_ready"}, 32'(req0_ready), 32'(v.e_r0rdy));
    check({tag, ".req1_ready"}, 32'(req1_ready), 32'(v.e_r1rdy));
    check({tag, ".select"},     32'(select),     32'(v.e_sel));
    @(posedge clk);
    #1;
    check({tag, ".out_valid"},  32'(out_valid),  32'(v.e_ov));
    check({tag, ".out_data"},   32'(out_data),   32'(v.e_od));
    check({tag, ".out_src"},    32'(out_src),    32'(v.e_os));
  endtask

  task automatic runTable(input vec_t vecs[$], input string name);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("%s[%0d]", name, i));
      @(negedge clk);
    end
  endtask

  initial begin
    // Round robin, both requesters continuously valid.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        mainVecs.push_back(mk(1, 4'hA, 1, 1, 4'h5, 1, 1, 1, 0, 0, 1, 4'hA, 0));
      else
        mainVecs.push_back(mk(1, 4'hA, 1, 1, 4'h5, 1, 1, 0, 1, 1, 1, 4'h5, 1));
    end
    // Downstream stall while full: nothing accepted, beat held.
    for (int i = 0; i < 3; i++)
      mainVecs.push_back(mk(1, 4'hA, 1, 1, 4'h5, 1, 0, 0, 0, 0, 1, 4'h5, 1));
    // Stall released: drain and accept in the same cycle.
    mainVecs.push_back(mk(1, 4'hA, 1, 1, 4'h5, 1, 1, 1, 0, 0, 1, 4'hA, 0));
    // Only requester 1 for three beats.
    mainVecs.push_back(mk(0, 4'h0, 1, 1, 4'h1, 1, 1, 0, 1, 1, 1, 4'h1, 1));
    mainVecs.push_back(mk(0, 4'h0, 1, 1, 4'h2, 1, 1, 0, 1, 1, 1, 4'h2, 1));
    mainVecs.push_back(mk(0, 4'h0, 1, 1, 4'h3, 1, 1, 0, 1, 1, 1, 4'h3, 1));
    // Both valid again: requester 0 wins.
    mainVecs.push_back(mk(1, 4'hC, 1, 1, 4'h9, 1, 1, 1, 0, 0, 1, 4'hC, 0));
    // Idle with drain: select holds 0 although prio is now 1.
    mainVecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 1, 1, 0, 0, 0, 0, 4'hC, 0));
    mainVecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 1, 0, 0, 0, 0, 0, 4'hC, 0));
    // Empty slot accepts even with out_ready low.
    mainVecs.push_back(mk(0, 4'h0, 1, 1, 4'hE, 1, 0, 0, 1, 1, 1, 4'hE, 1));
    // Full and stalled, idle: select holds 1.
    mainVecs.push_back(mk(0, 4'h0, 1, 0, 4'h0, 1, 0, 0, 0, 1, 1, 4'hE, 1));

    // Burst lock: requester 1 sends last=0,0,1 while requester 0 waits.
    lockVecs.push_back(mk(1, 4'h1, 1, 0, 4'h0, 1, 1, 1, 0, 0, 1, 4'h1, 0));
    lockVecs.push_back(mk(1, 4'h2, 1, 1, 4'h7, 0, 1, 0, 1, 1, 1, 4'h7, 1));
    lockVecs.push_back(mk(1, 4'h2, 1, 0, 4'h0, 0, 1, 0, 0, 1, 0, 4'h7, 1));
    lockVecs.push_back(mk(1, 4'h2, 1, 1, 4'h8, 0, 1, 0, 1, 1, 1, 4'h8, 1));
    lockVecs.push_back(mk(1, 4'h2, 1, 1, 4'h9, 1, 1, 0, 1, 1, 1, 4'h9, 1));
    lockVecs.push_back(mk(1, 4'h2, 1, 1, 4'h3, 1, 1, 1, 0, 0, 1, 4'h2, 0));
  end

  initial begin
    vec_t preReset;
    vec_t postReset;

    rst_n = 1'b0;
    applyStimulus(mk(1, 4'hA, 1, 1, 4'h5, 1, 1, 0, 0, 0, 0, 4'h0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.req0_ready", 32'(req0_ready), 32'd0);
    check("reset.req1_ready", 32'(req1_ready), 32'd0);
    check("reset.out_valid",  32'(out_valid),  32'd0);
    check("reset.select",     32'(select),     32'd0);
    rst_n = 1'b1;

    runTable(mainVecs, "main");
`ifdef VL_MUX2_ARB_LOCK_EN
    runTable(lockVecs, "lock");
`endif

    // Reset while full (and locked to requester 1 when the lock is built).
    preReset = mk(0, 4'h0, 1, 1, 4'h6, 0, 1, 0, 1, 1, 1, 4'h6, 1);
    applyStimulus(preReset);
    checkOutput(preReset, "prereset");
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset.out_valid",  32'(out_valid),  32'd0);
    check("midreset.out_data",   32'(out_data),   32'd0);
    check("midreset.out_src",    32'(out_src),    32'd0);
    check("midreset.req1_ready", 32'(req1_ready), 32'd0);
    check("midreset.select",     32'(select),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    postReset = mk(1, 4'hB, 1, 1, 4'h4, 1, 1, 1, 0, 0, 1, 4'hB, 0);
    applyStimulus(postReset);
    checkOutput(postReset, "postreset");

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
